rv_fetch_ctrl: RTL

Instruction-fetch sequencer for the RISC-V core's instruction-memory interface. It owns the fetch PC and issues one request at a time to instruction memory using a req/gnt/rvalid handshake. It captures each returned instruction into a single-entry output buffer for decode, and applies branch/jump redirects from execute, discarding any in-flight stale response. Sits between the PC-target logic (which supplies redirect targets) and the instruction memory port.

---
 rtl/rv_fetch_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/rv_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one imem request at
// a time, buffers the returned instruction for decode and applies redirects.
//
// state | meaning
// REQ   | presenting pc to imem (when the buffer is free), waiting for gnt
// WAIT  | request granted, waiting for the single rvalid response
module rv_fetch_ctrl #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  input  logic                   stall_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o
);

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_req;
  logic                  discard;
  logic                  free;
  logic                  consume;

  // Buffer can take a new instruction if empty or being drained this cycle.
  always_comb begin
    free    = !instr_valid_o || !stall_i;
    consume = instr_valid_o && !stall_i;
  end

  // Request only from REQ with room in the buffer; redirect and reset mask it.
  always_comb begin
    imem_req_o  = rst && (state == ST_REQ) && free && !redirect_i;
    imem_addr_o = pc;
  end

  // Fetch FSM, PC, stale-response tracking and output buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_REQ;
      pc            <= RESET_PC;
      pc_req        <= '0;
      discard       <= 1'b0;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      instr_pc_o    <= '0;
    end else begin
      if (consume) instr_valid_o <= 1'b0;
      if (redirect_i) begin
        pc            <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
        instr_valid_o <= 1'b0;
        if (state == ST_WAIT) begin
          // A response arriving with the redirect is dropped right here;
          // otherwise it is still in flight and must be swallowed later.
          if (imem_rvalid_i) begin
            state   <= ST_REQ;
            discard <= 1'b0;
          end else begin
            discard <= 1'b1;
          end
        end
      end else begin
        case (state)
          ST_REQ: begin
            if (imem_req_o && imem_gnt_i) begin
              pc_req <= pc;
              pc     <= pc + ADDR_WIDTH'(4);
              state  <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (imem_rvalid_i) begin
              if (!discard) begin
                instr_o       <= imem_rdata_i;
                instr_pc_o    <= pc_req;
                instr_valid_o <= 1'b1;
              end
              discard <= 1'b0;
              state   <= ST_REQ;
            end
          end
          default: state <= ST_REQ;
        endcase
      end
    end
  end

endmodule
